// File: rtl/seq_addsub_rca_if.sv
// Bundles the operand/result handshake of seq_addsub_rca.
// start is a request that is accepted only on a rising edge where busy=0; done pulses for one
// cycle with sum/cout/ovf valid, and those outputs hold until the next completion.
interface seq_addsub_rca_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             state_dbg;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, cout, ovf, state_dbg
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, cout, ovf, state_dbg
  );
endinterface

// File: rtl/seq_addsub_rca.sv
// Multi-cycle ripple-carry adder/subtractor: one DIGIT-bit ripple chain per cycle, LSB digit first,
// with the carry held in a register between digits.
module seq_addsub_rca #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic              clk,
  input logic              rst,
  seq_addsub_rca_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $fatal(1, "seq_addsub_rca: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] xa, yb, acc, acc_next;
  logic [DIGIT-1:0] dx, dy, ds;
  logic [DIGIT:0]   dc;
  logic             last;

  // Digit datapath: dc[DIGIT-1] is the carry entering the top cell, i.e. into the MSB on the last digit.
  always_comb begin
    dx       = xa[int'(cnt) * DIGIT +: DIGIT];
    dy       = yb[int'(cnt) * DIGIT +: DIGIT];
    dc       = '0;
    ds       = '0;
    dc[0]    = carry;
    for (int i = 0; i < DIGIT; i++) begin
      ds[i]   = dx[i] ^ dy[i] ^ dc[i];
      dc[i+1] = (dx[i] & dy[i]) | (dy[i] & dc[i]) | (dx[i] & dc[i]);
    end
    acc_next = acc;
    acc_next[int'(cnt) * DIGIT +: DIGIT] = ds;
    last     = (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      carry    <= 1'b0;
      xa       <= '0;
      yb       <= '0;
      acc      <= '0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            xa    <= bus.a;
            yb    <= bus.mode ? ~bus.b : bus.b;
            carry <= bus.mode ? ~bus.cin : bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= dc[DIGIT];
          if (last) begin
            cnt      <= '0;
            bus.sum  <= acc_next;
            bus.cout <= dc[DIGIT];
            bus.ovf  <= dc[DIGIT] ^ dc[DIGIT-1];
            bus.done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.state_dbg = (state == RUN);
endmodule

// File: tb/tb_seq_addsub_rca.sv
// Directed bench for seq_addsub_rca: DIGIT=4 (main), DIGIT=1 and DIGIT=16 instances share the
// same stimulus; each scenario task checks its own results.
module tb_seq_addsub_rca;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_addsub_rca_if #(.WIDTH(16)) if4  ();
  seq_addsub_rca_if #(.WIDTH(16)) if1  ();
  seq_addsub_rca_if #(.WIDTH(16)) if16 ();

  assign if4.start  = start;  assign if4.mode  = mode;  assign if4.a  = a;  assign if4.b  = b;  assign if4.cin  = cin;
  assign if1.start  = start;  assign if1.mode  = mode;  assign if1.a  = a;  assign if1.b  = b;  assign if1.cin  = cin;
  assign if16.start = start;  assign if16.mode = mode;  assign if16.a = a;  assign if16.b = b;  assign if16.cin = cin;

  seq_addsub_rca #(.WIDTH(16), .DIGIT(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_addsub_rca #(.WIDTH(16), .DIGIT(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_addsub_rca #(.WIDTH(16), .DIGIT(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  typedef struct {
    logic        m;
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue(input logic m, input logic [15:0] x, input logic [15:0] y, input logic ci);
    mode  = m;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait4(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!if4.done && lat < 20) begin
      if (if4.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if4.busy, if4.done, if4.sum, if4.cout, if4.ovf, if4.state_dbg} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_dut4: got %h expected 0", {if4.busy, if4.done, if4.sum, if4.cout, if4.ovf, if4.state_dbg});
    end
    n_vec++;
    if ({if1.busy, if1.done, if1.sum, if1.cout, if1.ovf, if16.busy, if16.done, if16.sum, if16.cout, if16.ovf} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_dut1_dut16: got %h expected 0",
               {if1.busy, if1.done, if1.sum, if1.cout, if1.ovf, if16.busy, if16.done, if16.sum, if16.cout, if16.ovf});
    end
  endtask

  task automatic test_add_wrap;
    int lat, nbusy;
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait4(lat, nbusy);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL add_wrap_latency: got %0d expected 4", lat); end
    n_vec++;
    if (nbusy !== 4) begin n_err++; $display("FAIL add_wrap_busy_cycles: got %0d expected 4", nbusy); end
    n_vec++;
    if ({if4.sum, if4.cout, if4.ovf, if4.busy} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_wrap_result: got sum=%h cout=%b ovf=%b busy=%b expected 0000 1 0 0",
               if4.sum, if4.cout, if4.ovf, if4.busy);
    end
    @(negedge clk);
    n_vec++;
    if (if4.done !== 1'b0) begin n_err++; $display("FAIL add_wrap_done_pulse: got %b expected 0", if4.done); end
  endtask

  task automatic test_busy_ignore;
    int lat, nbusy, ndone;
    issue(1'b0, 16'h1234, 16'h4321, 1'b1);
    mode  = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 2;
    while (!if4.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL busy_ignore_latency: got %0d expected 4", lat); end
    n_vec++;
    if ({if4.sum, if4.cout, if4.ovf} !== {16'h5556, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL busy_ignore_result: got sum=%h cout=%b ovf=%b expected 5556 0 0", if4.sum, if4.cout, if4.ovf);
    end
    ndone = 0;
    nbusy = 0;
    repeat (6) begin
      @(negedge clk);
      if (if4.done) ndone++;
      if (if4.busy) nbusy++;
    end
    n_vec++;
    if (ndone !== 0 || nbusy !== 0) begin
      n_err++;
      $display("FAIL busy_ignore_no_restart: got done=%0d busy=%0d expected 0 0", ndone, nbusy);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nbusy;
    issue(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait4(lat, nbusy);
    n_vec++;
    if ({if4.sum, if4.cout, if4.ovf} !== {16'h7FFF, 1'b1, 1'b1} || lat !== 4) begin
      n_err++;
      $display("FAIL b2b_first: got sum=%h cout=%b ovf=%b lat=%0d expected 7fff 1 1 4", if4.sum, if4.cout, if4.ovf, lat);
    end
    issue(1'b1, 16'h0003, 16'h0005, 1'b0);
    lat = 0;
    while (!if4.done && lat < 20) begin
      if (lat == 2) begin
        n_vec++;
        if (if4.sum !== 16'h7FFF) begin n_err++; $display("FAIL b2b_sum_hold: got %h expected 7fff", if4.sum); end
      end
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    n_vec++;
    if ({if4.sum, if4.cout, if4.ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b expected fffe 0 0", if4.sum, if4.cout, if4.ovf);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, nbusy, ndone;
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({if4.busy, if4.done, if4.sum, if4.cout, if4.ovf} !== 20'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h expected 0", {if4.busy, if4.done, if4.sum, if4.cout, if4.ovf});
    end
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (if4.done) ndone++;
    end
    n_vec++;
    if (ndone !== 0 || if4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_no_done: got done=%0d busy=%b expected 0 0", ndone, if4.busy);
    end
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    wait4(lat, nbusy);
    n_vec++;
    if ({if4.sum, if4.cout, if4.ovf} !== {16'h8000, 1'b0, 1'b1} || lat !== 4) begin
      n_err++;
      $display("FAIL mid_reset_recover: got sum=%h cout=%b ovf=%b lat=%0d expected 8000 0 1 4",
               if4.sum, if4.cout, if4.ovf, lat);
    end
  endtask

  task automatic test_digit_sweep;
    vec_t        v[12];
    int          lat, l4, l1, l16, wt;
    int          exp_lat[3];
    int          got_lat[3];
    logic [17:0] got[3];
    v[0]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[1]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[2]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    v[3]  = '{1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    v[4]  = '{1'b1, 16'h000A, 16'h0003, 1'b1, 16'h0006, 1'b1, 1'b0};
    v[5]  = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    v[6]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    v[7]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    v[8]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    v[9]  = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[10] = '{1'b1, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[11] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    exp_lat = '{4, 16, 1};
    wt = 0;
    while (if1.busy && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    for (int k = 0; k < 12; k++) begin
      issue(v[k].m, v[k].x, v[k].y, v[k].ci);
      lat = 0; l4 = 0; l1 = 0; l16 = 0;
      while (l1 == 0 && lat < 40) begin
        @(negedge clk);
        lat++;
        if (if4.done  && l4  == 0) l4  = lat;
        if (if1.done  && l1  == 0) l1  = lat;
        if (if16.done && l16 == 0) l16 = lat;
      end
      got_lat = '{l4, l1, l16};
      got[0]  = {if4.sum, if4.cout, if4.ovf};
      got[1]  = {if1.sum, if1.cout, if1.ovf};
      got[2]  = {if16.sum, if16.cout, if16.ovf};
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (got_lat[d] !== exp_lat[d]) begin
          n_err++;
          $display("FAIL sweep_latency vec%0d inst%0d: got %0d expected %0d", k, d, got_lat[d], exp_lat[d]);
        end
        n_vec++;
        if (got[d] !== {v[k].s, v[k].co, v[k].ov}) begin
          n_err++;
          $display("FAIL sweep_result vec%0d inst%0d: got sum=%h cout=%b ovf=%b expected %h %b %b",
                   k, d, got[d][17:2], got[d][1], got[d][0], v[k].s, v[k].co, v[k].ov);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_digit_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
